// File: rtl/slink_pkg.sv
// Shared S-Link definitions: receive-checker state encoding, CRC-16/MCRF4XX constants
// and the byte-wide reflected CRC update used by the compute stage.
package slink_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_CRC_LO  = 3'd2,
    ST_CRC_HI  = 3'd3,
    ST_REPORT  = 3'd4
  } slink_state_e;

  localparam logic [15:0] SLINK_CRC_INIT      = 16'hFFFF;
  localparam int          SLINK_CRC_LEN_BYTES = 2;
  localparam logic [15:0] SLINK_CRC_POLY_REFL = 16'h8408;

  // LSB-first update: fold the byte into the low end, then shift out eight bits.
  function automatic logic [15:0] slink_crc16_byte(input logic [15:0] crc,
                                                   input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ SLINK_CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/slink_crc_8_16bit_compute.sv
// CRC-16/MCRF4XX compute stage: one byte per valid cycle, registered result,
// re-initialised to 0xFFFF on init.
module slink_crc_8_16bit_compute
  import slink_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        valid,
  input  logic        init,
  input  logic [15:0] crc_prev,
  output logic [15:0] crc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= SLINK_CRC_INIT;
    end else if (init) begin
      crc <= SLINK_CRC_INIT;
    end else if (valid) begin
      crc <= slink_crc16_byte(crc_prev, data_in);
    end
  end

endmodule

// File: rtl/slink_crc_rx_check.sv
// Receive-side packet CRC checker: forwards payload bytes with zero latency, consumes the
// two-byte CRC trailer, and reports pass/fail plus a saturating error count.
module slink_crc_rx_check
  import slink_pkg::*;
#(
  parameter int LEN_W    = 16,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic                out_last,
  output logic                busy,
  output logic                crc_done,
  output logic                crc_err,
  output logic [15:0]         crc_calc,
  output logic [15:0]         crc_rx,
  output logic [ERRCNT_W-1:0] err_count
);

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + ERRCNT_W'(1);
  endfunction

  slink_state_e        state_q, state_d;
  logic [LEN_W-1:0]    remaining_q;
  logic [7:0]          rx_lo_q;
  logic [15:0]         crc_rx_q;
  logic [15:0]         crc_calc_q;
  logic                crc_err_q;
  logic [ERRCNT_W-1:0] err_count_q;
  logic [15:0]         crc_reg;

  logic accept, start_acc, pay_acc, lo_acc, hi_acc, crc_init;

  // abort outranks every accept in the same cycle, so the byte is simply dropped
  assign accept    = in_valid & in_ready;
  assign start_acc = (state_q == ST_IDLE)    & start  & ~abort;
  assign pay_acc   = (state_q == ST_PAYLOAD) & accept & ~abort;
  assign lo_acc    = (state_q == ST_CRC_LO)  & accept & ~abort;
  assign hi_acc    = (state_q == ST_CRC_HI)  & accept & ~abort;
  assign crc_init  = start_acc | abort;

  slink_crc_8_16bit_compute u_crc (
    .clk      (clk),
    .reset    (reset),
    .data_in  (in_data),
    .valid    (pay_acc),
    .init     (crc_init),
    .crc_prev (crc_reg),
    .crc      (crc_reg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start_acc) state_d = (len != '0) ? ST_PAYLOAD : ST_CRC_LO;
      ST_PAYLOAD: if (pay_acc && remaining_q == LEN_W'(1)) state_d = ST_CRC_LO;
      ST_CRC_LO:  if (lo_acc) state_d = ST_CRC_HI;
      ST_CRC_HI:  if (hi_acc) state_d = ST_REPORT;
      ST_REPORT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    crc_done  = 1'b0;
    unique case (state_q)
      ST_PAYLOAD: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        out_last  = (remaining_q == LEN_W'(1));
      end
      ST_CRC_LO, ST_CRC_HI: in_ready = 1'b1;
      ST_REPORT:            crc_done = ~abort;
      default:              ;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign out_data = in_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining_q <= '0;
      rx_lo_q     <= '0;
      crc_rx_q    <= '0;
      crc_calc_q  <= SLINK_CRC_INIT;
      crc_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (start_acc) begin
        remaining_q <= len;
      end else if (pay_acc) begin
        remaining_q <= remaining_q - LEN_W'(1);
      end
      if (lo_acc) rx_lo_q <= in_data;
      if (hi_acc) begin
        crc_rx_q   <= {in_data, rx_lo_q};
        crc_calc_q <= crc_reg;
        crc_err_q  <= (crc_reg != {in_data, rx_lo_q});
      end
      if (crc_done && crc_err_q) err_count_q <= sat_inc(err_count_q);
    end
  end

  assign crc_err   = crc_err_q;
  assign crc_calc  = crc_calc_q;
  assign crc_rx    = crc_rx_q;
  assign err_count = err_count_q;

endmodule

// File: doc/slink_crc_rx_check.md
# slink_crc_rx_check

Receive-side packet CRC checker for the S-Link byte path. It sits directly downstream of the byte deserializer / packet-header decoder and wraps the existing CRC-16 compute stage (CRC-16/MCRF4XX: reflected poly 0x8408, init 0xFFFF, no final XOR). For each packet it passes the payload bytes through to the application, consumes the 2-byte CRC trailer, and reports pass/fail plus a saturating error count.

## Interface
- `LEN_W`, default 16: width of the payload byte count.
- `ERRCNT_W`, default 8: width of the saturating CRC error counter.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  packet start pulse; sampled only in IDLE.
- `len`  in  LEN_W  payload byte count, sampled with `start`; the trailer is not included.
- `abort`  in  1  synchronous abandon of the current packet.
- `in_valid`  in  1  input byte valid.
- `in_ready`  out  1  input byte accepted when `in_valid & in_ready`.
- `in_data`  in  8  input byte (payload, then CRC low byte, then CRC high byte).
- `out_valid`  out  1  payload byte to the application.
- `out_ready`  in  1  application backpressure.
- `out_data`  out  8  payload byte.
- `out_last`  out  1  marks the final payload byte.
- `busy`  out  1  state is not IDLE.
- `crc_done`  out  1  one-cycle pulse: result valid.
- `crc_err`  out  1  1 = mismatch; valid with `crc_done`, held until the next `crc_done`.
- `crc_calc`  out  16  computed CRC; held.
- `crc_rx`  out  16  received CRC `{hi,lo}`; held.
- `err_count`  out  ERRCNT_W  saturating count of failed packets.

## Operation
States: IDLE, PAYLOAD, CRC_LO, CRC_HI, REPORT.

- **IDLE**
  - `in_ready=0`.
  - On `start & !abort`: init the CRC to 0xFFFF and load `remaining=len`.
  - Go to PAYLOAD if `len!=0`, otherwise go to CRC_LO.
- **PAYLOAD**
  - `out_valid=in_valid`, `out_data=in_data`, `in_ready=out_ready` (combinational pass-through).
  - Each accepted byte updates the CRC and decrements `remaining`.
  - `out_last=(remaining==1)`.
  - Accepting the byte with `remaining==1` moves to CRC_LO.
- **CRC_LO**
  - `in_ready=1`; nothing is forwarded and the CRC is not updated.
  - The accepted byte is stored as `rx_lo`; go to CRC_HI.
- **CRC_HI**
  - `in_ready=1`.
  - On accept: `crc_rx<={in_data,rx_lo}`, `crc_calc<=crc register`, `crc_err<=(crc_register!={in_data,rx_lo})`; go to REPORT.
- **REPORT**
  - `crc_done=1` for exactly one cycle.
  - If `crc_err`, increment `err_count`, saturating at all-ones.
  - Go to IDLE.
- **`abort`**
  - In any non-IDLE state: go to IDLE next cycle, with no `crc_done` and no `err_count` change.
  - `abort` wins over `start` in the same cycle, and over a byte accept in the same cycle; that byte is dropped.
- **`start` outside IDLE:** ignored.
- **`len` of all-ones:** supported; no wrap, because the counter only decrements toward 1.
- **Empty payload:** an empty payload (CRC 0xFFFF) is legal.
- **`reset`, including mid-packet:**
  - Returns to IDLE.
  - CRC register 0xFFFF; `crc_calc` 0xFFFF; `crc_rx`, `remaining`, `rx_lo`, `err_count` all 0.
  - `busy`, `crc_done`, `crc_err`, `out_valid`, `out_last`, `in_ready` all 0.
  - `out_data` passes `in_data` and is don't-care while `out_valid=0`.

## Timing
- Payload path: zero latency. The byte appears on `out_*` in the same cycle it is presented.
- `crc_done` is asserted the cycle after the CRC high byte is accepted.
- `busy` deasserts the cycle after that.
- Minimum packet cost: `len+3` cycles, i.e. `len` payload + 2 trailer + 1 REPORT. The next `start` is accepted in the IDLE cycle that follows.
- `in_ready` depends combinationally on `out_ready` in PAYLOAD only. There is no combinational path from `in_valid` to `in_ready`.
- The CRC register is updated only on an accepted PAYLOAD byte, so backpressure stalls leave it unchanged.

## Structure
- Instantiate the existing `slink_crc_8_16bit_compute` once:
  - `data_in=in_data`
  - `valid=` accepted PAYLOAD byte
  - `init=` accepted `start` or `abort`
  - `crc_prev=` its own `crc` output
- Use the `crc` output as the running CRC register.
- Shared package (`slink_pkg`):
  - state enum for the five states
  - `SLINK_CRC_INIT=16'hFFFF`
  - `SLINK_CRC_LEN_BYTES=2`
- All other logic is local: FSM, `remaining` counter, `rx_lo`, result registers, saturating counter.

## Test plan
- **Known vector:** `len=24`, bytes `FF 00 00 00 1E F0 1E C7 4F 82 78 C5 82 E0 8C 70 D2 3C 78 E9 FF 00 00 01`, then trailer `69 E5`.
  - Expect 24 bytes out with `out_last` on `01`.
  - Expect `crc_done=1`, `crc_err=0`, `crc_calc=crc_rx=16'hE569`, `err_count=0`.
- **Corrupted trailer:** same payload, trailer `68 E5`.
  - Expect `crc_err=1`, `crc_rx=16'hE568`, `crc_calc=16'hE569`, `err_count=1`.
- **Empty payload:** `len=0`, trailer `FF FF`.
  - Expect no `out_valid`, `crc_done` 3 cycles after `start`, `crc_err=0`.
- **Backpressure:** known vector with `out_ready=0` for 3 cycles after byte 10.
  - Expect `in_ready=0` during the stall and no duplicated or lost bytes.
  - Expect the final result to pass with `crc_calc=16'hE569`.
- **Reset / abort mid-packet:**
  - Assert `reset` after byte 5: all outputs go to reset values. A following known-vector packet passes.
  - Assert `abort` after byte 5: no `crc_done`. A following known-vector packet passes.
- **Saturation:** 257 corrupted packets. Expect `err_count` to stick at 255.
